// File: rtl/inv_mix_col_iter_if.sv
// inv_mix_col_iter_if: input handshake, held output handshake and busy flag
// for the column-serial InvMixColumns engine.
interface inv_mix_col_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output busy
  );
endinterface

// File: rtl/inv_mix_col_iter.sv
// inv_mix_col_iter: column-serial AES InvMixColumns, COLS_PER_CYCLE columns
// rewritten in place per clock; result held until the consumer takes it.
module inv_mix_col_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              rst,
  inv_mix_col_iter_if.slave bus
);

  if (!(COLS_PER_CYCLE == 1 ||
        COLS_PER_CYCLE == 2 ||
        COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] Step = 2'(COLS_PER_CYCLE);

  state_t       state;
  logic [127:0] work;
  logic [127:0] nxt;
  logic [1:0]   cnt;
  logic         idle_q;
  logic         run_q;
  logic         done_q;
  logic         last;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul_9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul_b(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] mul_d(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul_e(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] b [4];
    for (int r = 0; r < 4; r++) begin
      a[r] = c[31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      b[r] = mul_e(a[r]) ^
             mul_b(a[(r+1)%4]) ^
             mul_d(a[(r+2)%4]) ^
             mul_9(a[(r+3)%4]);
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic int col_msb(input logic [1:0] c);
    return 127 - 32 * int'(c);
  endfunction

  // Only the selected columns change; the rest pass through untouched.
  always_comb begin
    nxt = work;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      nxt[col_msb(cnt + 2'(i)) -: 32] =
        inv_col(work[col_msb(cnt + 2'(i)) -: 32]);
    end
  end

  assign last = (int'(cnt) + COLS_PER_CYCLE) >= 4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      idle_q <= 1'b1;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work   <= bus.in_data;
            cnt    <= '0;
            state  <= RUN;
            idle_q <= 1'b0;
            run_q  <= 1'b1;
          end
        end
        RUN: begin
          work <= nxt;
          cnt  <= cnt + Step;
          if (last) begin
            state  <= DONE;
            run_q  <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state  <= IDLE;
            done_q <= 1'b0;
            idle_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          idle_q <= 1'b1;
          run_q  <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Gated by rst so nothing is offered while reset is held.
  assign bus.in_ready  = idle_q & ~rst;
  assign bus.out_valid = done_q;
  assign bus.busy      = run_q;
  assign bus.out_data  = work;

endmodule

// File: tb/tb_inv_mix_col_iter.sv
// tb_inv_mix_col_iter: directed vectors for the InvMixColumns engine at
// COLS_PER_CYCLE 1, 2 and 4, with hand-derived expectations.
module tb_inv_mix_col_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inv_mix_col_iter_if b1 ();
  inv_mix_col_iter_if b2 ();
  inv_mix_col_iter_if b4 ();

  inv_mix_col_iter #(.COLS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  inv_mix_col_iter #(.COLS_PER_CYCLE(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2.slave));
  inv_mix_col_iter #(.COLS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst(rst), .bus(b4.slave));

  logic         iv  = 1'b0;
  logic         orr = 1'b0;
  logic [127:0] id  = '0;
  int           sel = 1;

  assign b1.in_valid  = iv && sel == 1;
  assign b2.in_valid  = iv && sel == 2;
  assign b4.in_valid  = iv && sel == 4;
  assign b1.out_ready = orr && sel == 1;
  assign b2.out_ready = orr && sel == 2;
  assign b4.out_ready = orr && sel == 4;
  assign b1.in_data   = id;
  assign b2.in_data   = id;
  assign b4.in_data   = id;

  logic         ir;
  logic         ov;
  logic         bz;
  logic [127:0] od;

  always_comb begin
    ir = b1.in_ready;
    ov = b1.out_valid;
    bz = b1.busy;
    od = b1.out_data;
    if (sel == 2) begin
      ir = b2.in_ready;
      ov = b2.out_valid;
      bz = b2.busy;
      od = b2.out_data;
    end else if (sel == 4) begin
      ir = b4.in_ready;
      ov = b4.out_valid;
      bz = b4.busy;
      od = b4.out_data;
    end
  end

  int ncmp = 0;
  int nerr = 0;

  localparam logic [127:0] FipsIn  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] FipsOut = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] KnownIn  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] KnownOut = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] x2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns, used to build round-trip stimulus.
  function automatic logic [127:0] mixcols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        o[127-32*c-8*r -: 8] = x2(a[r]) ^ x2(a[(r+1)%4]) ^
          a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
    end
    return o;
  endfunction

  task automatic xfer(input logic [127:0] d, input int hold,
                      input bit poke, output logic [127:0] r,
                      output int lat, output int runlen);
    logic [127:0] first;
    chk("in_ready_idle", 128'(ir), 128'(1));
    iv  = 1'b1;
    id  = d;
    orr = 1'b0;
    @(negedge clk);
    iv     = poke;
    id     = ~d;
    lat    = 1;
    runlen = 0;
    while (!ov && lat < 20) begin
      if (bz) runlen++;
      if (poke) chk("in_ready_run", 128'(ir), 128'(0));
      @(negedge clk);
      lat++;
    end
    chk("out_valid_seen", 128'(ov), 128'(1));
    first = od;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 128'(ov), 128'(1));
      chk("hold_data", od, first);
      chk("in_ready_done", 128'(ir), 128'(0));
      chk("busy_done", 128'(bz), 128'(0));
      @(negedge clk);
    end
    iv  = 1'b0;
    r   = od;
    orr = 1'b1;
    @(negedge clk);
    orr = 1'b0;
    chk("out_valid_drop", 128'(ov), 128'(0));
    chk("in_ready_back", 128'(ir), 128'(1));
  endtask

  logic [127:0] res;
  logic [127:0] rt [3];
  int           lat;
  int           rl;

  initial begin
    rt[0] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    rt[1] = 128'h84e1dd691a41d76f792d389783fbac70;
    rt[2] = 128'h1fb5430ef0accf64aa370cde3d77792c;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(ir), 128'(0));
    chk("rst_out_valid", 128'(ov), 128'(0));
    chk("rst_busy", 128'(bz), 128'(0));
    chk("rst_out_data", od, 128'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(ir), 128'(1));

    xfer(128'h0, 0, 1'b0, res, lat, rl);
    chk("zero_data", res, 128'h0);
    chk("zero_latency", 128'(lat), 128'(5));
    chk("zero_runlen", 128'(rl), 128'(4));

    xfer(FipsIn, 0, 1'b0, res, lat, rl);
    chk("fips_data", res, FipsOut);
    chk("fips_latency", 128'(lat), 128'(5));

    xfer(KnownIn, 0, 1'b0, res, lat, rl);
    chk("known_data", res, KnownOut);

    for (int i = 0; i < 3; i++) begin
      xfer(mixcols(rt[i]), 0, 1'b0, res, lat, rl);
      chk("round_trip", res, rt[i]);
    end

    xfer(KnownIn, 10, 1'b1, res, lat, rl);
    chk("bp_data", res, KnownOut);
    chk("bp_runlen", 128'(rl), 128'(4));

    // Reset two cycles into RUN, with in_valid held high alongside it.
    iv = 1'b1;
    id = FipsIn;
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    iv  = 1'b1;
    #1;
    chk("midrun_in_ready", 128'(ir), 128'(0));
    chk("midrun_out_valid", 128'(ov), 128'(0));
    chk("midrun_busy", 128'(bz), 128'(0));
    chk("midrun_out_data", od, 128'h0);
    @(negedge clk);
    chk("midrun_hold_data", od, 128'h0);
    rst = 1'b0;
    iv  = 1'b0;
    #1;
    chk("midrun_release_ready", 128'(ir), 128'(1));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrun_no_emit", 128'(ov), 128'(0));
      chk("midrun_no_capture", od, 128'h0);
    end
    xfer(FipsIn, 0, 1'b0, res, lat, rl);
    chk("after_rst_data", res, FipsOut);

    sel = 2;
    #1;
    xfer(FipsIn, 0, 1'b0, res, lat, rl);
    chk("c2_data", res, FipsOut);
    chk("c2_runlen", 128'(rl), 128'(2));
    chk("c2_latency", 128'(lat), 128'(3));

    sel = 4;
    #1;
    xfer(FipsIn, 0, 1'b0, res, lat, rl);
    chk("c4_data", res, FipsOut);
    chk("c4_runlen", 128'(rl), 128'(1));
    chk("c4_latency", 128'(lat), 128'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
